// File: rtl/fetch_unit.sv
// Instruction fetch unit: program counter, instruction register and a
// two-state fetch FSM with a 15-edge memory timeout.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   LoadIR              start a fetch at the current PC (ignored while busy)
//   IncPC, LoadPC       PC increment / jump load (LoadPC has priority)
//   SelPC               jump source: 1 = {4'h0, ImmediateData}, 0 = RegData
//   ImmediateData       4-bit jump-immediate target
//   RegData             8-bit jump-register target
//   MemAddr, MemReq     instruction memory address and read request
//   MemRdata, MemValid  instruction memory read data and its valid strobe
//   Opcode, IrValid     instruction register and its completed-fetch flag
//   Busy                fetch in progress
//   FetchErr            sticky memory-timeout flag
//   PC                  current program counter
module fetch_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       LoadIR,
    input  logic       IncPC,
    input  logic       LoadPC,
    input  logic       SelPC,
    input  logic [3:0] ImmediateData,
    input  logic [7:0] RegData,
    output logic [7:0] MemAddr,
    output logic       MemReq,
    input  logic [7:0] MemRdata,
    input  logic       MemValid,
    output logic [7:0] Opcode,
    output logic       IrValid,
    output logic       Busy,
    output logic       FetchErr,
    output logic [7:0] PC
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    // The wait counter starts at 0 on entry, so the edge that sees 14
    // is the 15th consecutive edge without MemValid.
    localparam logic [3:0] WAIT_LAST = 4'd14;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] fetch_addr_q, fetch_addr_d;
    logic [7:0] opcode_q, opcode_d;
    logic       ir_valid_q, ir_valid_d;
    logic       fetch_err_q, fetch_err_d;
    logic [3:0] wait_q, wait_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= 8'h00;
            fetch_addr_q <= 8'h00;
            opcode_q     <= 8'h00;
            ir_valid_q   <= 1'b0;
            fetch_err_q  <= 1'b0;
            wait_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            opcode_q     <= opcode_d;
            ir_valid_q   <= ir_valid_d;
            fetch_err_q  <= fetch_err_d;
            wait_q       <= wait_d;
        end
    end

    // PC update runs every edge regardless of fetch state.
    always_comb begin
        pc_d = pc_q;
        if (LoadPC) begin
            if (SelPC) begin
                pc_d = {4'h0, ImmediateData};
            end else begin
                pc_d = RegData;
            end
        end else if (IncPC) begin
            pc_d = pc_q + 8'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        opcode_d     = opcode_q;
        ir_valid_d   = ir_valid_q;
        fetch_err_d  = fetch_err_q;
        wait_d       = wait_q;
        unique case (state_q)
            IDLE: begin
                // pc_q is the pre-update PC, so a coincident jump or
                // increment does not move this fetch.
                if (LoadIR) begin
                    fetch_addr_d = pc_q;
                    ir_valid_d   = 1'b0;
                    wait_d       = 4'd0;
                    state_d      = FETCH;
                end
            end
            FETCH: begin
                if (MemValid) begin
                    opcode_d   = MemRdata;
                    ir_valid_d = 1'b1;
                    state_d    = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    opcode_d    = 8'h00;
                    ir_valid_d  = 1'b0;
                    fetch_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Busy     = (state_q == FETCH);
    assign MemReq   = Busy;
    assign MemAddr  = Busy ? fetch_addr_q : pc_q;
    assign Opcode   = opcode_q;
    assign IrValid  = ir_valid_q;
    assign FetchErr = fetch_err_q;
    assign PC       = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table plus hand-written
// sequences for timeout, mid-fetch reset and first fetch after reset.
module tb_fetch_unit;

    logic       clk;
    logic       reset;
    logic       LoadIR;
    logic       IncPC;
    logic       LoadPC;
    logic       SelPC;
    logic [3:0] ImmediateData;
    logic [7:0] RegData;
    logic [7:0] MemAddr;
    logic       MemReq;
    logic [7:0] MemRdata;
    logic       MemValid;
    logic [7:0] Opcode;
    logic       IrValid;
    logic       Busy;
    logic       FetchErr;
    logic [7:0] PC;

    int n_cmp;
    int n_err;

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .LoadIR       (LoadIR),
        .IncPC        (IncPC),
        .LoadPC       (LoadPC),
        .SelPC        (SelPC),
        .ImmediateData(ImmediateData),
        .RegData      (RegData),
        .MemAddr      (MemAddr),
        .MemReq       (MemReq),
        .MemRdata     (MemRdata),
        .MemValid     (MemValid),
        .Opcode       (Opcode),
        .IrValid      (IrValid),
        .Busy         (Busy),
        .FetchErr     (FetchErr),
        .PC           (PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       li;
        logic       inc;
        logic       lpc;
        logic       sel;
        logic [3:0] imm;
        logic [7:0] rd;
        logic       mv;
        logic [7:0] md;
        logic [7:0] e_pc;
        logic [7:0] e_addr;
        logic       e_req;
        logic [7:0] e_op;
        logic       e_irv;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic li, input logic inc, input logic lpc,
        input logic sel, input logic [3:0] imm, input logic [7:0] rd,
        input logic mv, input logic [7:0] md,
        input logic [7:0] e_pc, input logic [7:0] e_addr,
        input logic e_req, input logic [7:0] e_op,
        input logic e_irv, input logic e_busy, input logic e_err);
        vec_t v;
        v.li = li; v.inc = inc; v.lpc = lpc; v.sel = sel;
        v.imm = imm; v.rd = rd; v.mv = mv; v.md = md;
        v.e_pc = e_pc; v.e_addr = e_addr; v.e_req = e_req;
        v.e_op = e_op; v.e_irv = e_irv; v.e_busy = e_busy;
        v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Packed view of all outputs: pc, addr, req, op, irv, busy, err.
    function automatic logic [31:0] outs();
        return {4'h0, PC, MemAddr, MemReq, Opcode, IrValid, Busy, FetchErr};
    endfunction

    function automatic logic [31:0] pack(
        input logic [7:0] pc, input logic [7:0] addr, input logic req,
        input logic [7:0] op, input logic irv, input logic busy,
        input logic err);
        return {4'h0, pc, addr, req, op, irv, busy, err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        LoadIR = 0; IncPC = 0; LoadPC = 0; SelPC = 0;
        ImmediateData = 4'h0; RegData = 8'h00;
        MemValid = 0; MemRdata = 8'h00;
    endtask

    initial begin
        int cycles;
        n_cmp = 0;
        n_err = 0;

        vecs[0]  = mk(1,0,0,0,4'h0,8'h00,0,8'h00, 8'h00,8'h00,1,8'h00,0,1,0);
        vecs[1]  = mk(0,0,0,0,4'h0,8'h00,1,8'h4A, 8'h00,8'h00,0,8'h4A,1,0,0);
        vecs[2]  = mk(0,0,0,0,4'h0,8'h00,1,8'hFF, 8'h00,8'h00,0,8'h4A,1,0,0);
        vecs[3]  = mk(0,0,1,0,4'h0,8'h05,0,8'h00, 8'h05,8'h05,0,8'h4A,1,0,0);
        vecs[4]  = mk(1,1,0,0,4'h0,8'h00,0,8'h00, 8'h06,8'h05,1,8'h4A,0,1,0);
        vecs[5]  = mk(1,1,0,0,4'h0,8'h00,0,8'h00, 8'h07,8'h05,1,8'h4A,0,1,0);
        vecs[6]  = mk(0,0,0,0,4'h0,8'h00,1,8'h3C, 8'h07,8'h07,0,8'h3C,1,0,0);
        vecs[7]  = mk(0,1,1,1,4'h9,8'hC3,0,8'h00, 8'h09,8'h09,0,8'h3C,1,0,0);
        vecs[8]  = mk(0,0,1,0,4'h9,8'hC3,0,8'h00, 8'hC3,8'hC3,0,8'h3C,1,0,0);
        vecs[9]  = mk(0,0,1,0,4'h0,8'hFF,0,8'h00, 8'hFF,8'hFF,0,8'h3C,1,0,0);
        vecs[10] = mk(0,1,0,0,4'h0,8'h00,0,8'h00, 8'h00,8'h00,0,8'h3C,1,0,0);
        vecs[11] = mk(1,0,0,0,4'h0,8'h00,0,8'h00, 8'h00,8'h00,1,8'h3C,0,1,0);
        vecs[12] = mk(0,0,1,1,4'hF,8'h00,0,8'h00, 8'h0F,8'h00,1,8'h3C,0,1,0);
        vecs[13] = mk(0,0,0,0,4'h0,8'h00,1,8'h81, 8'h0F,8'h0F,0,8'h81,1,0,0);

        idle_inputs();
        reset = 1'b1;
        #22;
        reset = 1'b0;
        #1;
        chk("reset_state", outs(),
            pack(8'h00, 8'h00, 0, 8'h00, 0, 0, 0));
        @(negedge clk);
        step();

        for (int i = 0; i < NV; i++) begin
            LoadIR = vecs[i].li;
            IncPC = vecs[i].inc;
            LoadPC = vecs[i].lpc;
            SelPC = vecs[i].sel;
            ImmediateData = vecs[i].imm;
            RegData = vecs[i].rd;
            MemValid = vecs[i].mv;
            MemRdata = vecs[i].md;
            step();
            chk($sformatf("vec%0d", i), outs(),
                pack(vecs[i].e_pc, vecs[i].e_addr, vecs[i].e_req,
                     vecs[i].e_op, vecs[i].e_irv, vecs[i].e_busy,
                     vecs[i].e_err));
        end
        idle_inputs();

        // Timeout: MemValid never arrives.
        LoadIR = 1;
        step();
        LoadIR = 0;
        chk("to_addr", {24'h0, MemAddr}, 32'h0F);
        cycles = 0;
        while (MemReq === 1'b1 && cycles < 20) begin
            cycles++;
            step();
        end
        chk("to_req_cycles", cycles, 15);
        chk("to_after", outs(),
            pack(8'h0F, 8'h0F, 0, 8'h00, 0, 0, 1));

        // Fetch after a timeout still works; error stays sticky.
        LoadIR = 1;
        step();
        LoadIR = 0;
        MemValid = 1;
        MemRdata = 8'h5A;
        step();
        idle_inputs();
        chk("post_to_fetch", outs(),
            pack(8'h0F, 8'h0F, 0, 8'h5A, 1, 0, 1));

        // Reset between edges during a fetch.
        LoadIR = 1;
        step();
        LoadIR = 0;
        chk("pre_rst_busy", {31'h0, Busy}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst", outs(),
            pack(8'h00, 8'h00, 0, 8'h00, 0, 0, 0));
        #1;
        reset = 1'b0;
        MemValid = 1;
        MemRdata = 8'h77;
        step();
        MemValid = 0;
        chk("late_valid", outs(),
            pack(8'h00, 8'h00, 0, 8'h00, 0, 0, 0));

        // First fetch after reset goes to address 0.
        LoadIR = 1;
        step();
        LoadIR = 0;
        chk("first_fetch", outs(),
            pack(8'h00, 8'h00, 1, 8'h00, 0, 1, 0));
        MemValid = 1;
        MemRdata = 8'h11;
        step();
        idle_inputs();
        chk("first_done", outs(),
            pack(8'h00, 8'h00, 0, 8'h11, 1, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
